scaler_h_step_ctrl: RTL

- Configuration sequencer for the horizontal bicubic scaler.
- Monitors the same pixel stream that feeds the scaler and measures the active input line width.
- Computes the 4.12 unsigned step `in_width*4096/out_width` with a serial restoring divider.
- Applies the new step only at a frame boundary, so the scaler never sees a step change mid-frame.

---
 rtl/scaler_h_step_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/scaler_h_step_ctrl.sv
// Horizontal scaler step sequencer: measures the active input line width, derives the
// 4.12 step in_width/out_width with a serial restoring divider and applies it at frame start.
`timescale 1ns/1ps
module scaler_h_step_ctrl #(
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned FRAC_BITS  = 12,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  cfg_out_width,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] scale_step_h,
  output logic                  step_upd_o,
  output logic [CNT_WIDTH-1:0]  in_width_o,
  output logic                  busy_o,
  output logic                  err_o
);
  localparam int unsigned QW = CNT_WIDTH + FRAC_BITS;
  localparam int unsigned CW = $clog2(QW);
  localparam logic [CW-1:0]         LAST_BIT = CW'(QW - 1);
  localparam logic [QW-1:0]         STEP_MAX = QW'((64'd1 << STEP_WIDTH) - 64'd1);
  localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(64'd1 << FRAC_BITS);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, DIVIDE, PENDING} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0]  in_width_q, in_width_d;
  logic                  meas_valid_q, meas_valid_d;
  logic                  width_chg_q, width_chg_d;
  logic [CNT_WIDTH-1:0]  out_width_q, out_width_d;
  logic                  err_q, err_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic [STEP_WIDTH-1:0] result_q, result_d;
  logic                  upd_q, upd_d;
  logic                  chg_seen_q, chg_seen_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [QW-1:0]         dvd_q, dvd_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [CNT_WIDTH-1:0]  div_q, div_d;

  logic                  cfg_acc, cfg_go, frame, start;
  logic [CNT_WIDTH:0]    rem_sh;
  logic [CNT_WIDTH-1:0]  rem_sub;
  logic                  q_bit;
  logic [QW-1:0]         quot;

  assign cfg_ready    = (state_q != DIVIDE);
  assign busy_o       = (state_q != IDLE);
  assign scale_step_h = step_q;
  assign step_upd_o   = upd_q;
  assign in_width_o   = in_width_q;
  assign err_o        = err_q;

  assign cfg_acc = cfg_valid && cfg_ready;
  assign cfg_go  = cfg_acc && (cfg_out_width != '0);
  assign frame   = de_i && vs_i;

  // Quotient bits shift into the dividend register as dividend bits leave it.
  assign rem_sh  = {rem_q, dvd_q[QW-1]};
  assign q_bit   = (rem_sh >= {1'b0, div_q});
  assign rem_sub = rem_sh[CNT_WIDTH-1:0] - div_q;
  assign quot    = {dvd_q[QW-2:0], q_bit};

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    in_width_d   = in_width_q;
    meas_valid_d = meas_valid_q;
    width_chg_d  = 1'b0;
    if (de_i) begin
      if (hs_i) begin
        pix_cnt_d = CNT_ONE;
        if (pix_cnt_q != '0) begin
          in_width_d   = pix_cnt_q;
          meas_valid_d = 1'b1;
          width_chg_d  = (pix_cnt_q != in_width_q);
        end
      end else if (pix_cnt_q != CNT_MAX) begin
        pix_cnt_d = pix_cnt_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_width_d = out_width_q;
    err_d       = err_q;
    step_d      = step_q;
    result_d    = result_q;
    upd_d       = 1'b0;
    chg_seen_d  = chg_seen_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    rem_d       = rem_q;
    div_d       = div_q;
    start       = 1'b0;

    if (cfg_acc) begin
      if (cfg_out_width == '0) begin
        err_d = 1'b1;
      end else begin
        out_width_d = cfg_out_width;
        err_d       = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_go || (width_chg_q && meas_valid_q && (out_width_q != '0))) start = 1'b1;
      end
      DIVIDE: begin
        cnt_d = cnt_q + CW'(1);
        dvd_d = quot;
        rem_d = q_bit ? rem_sub : rem_sh[CNT_WIDTH-1:0];
        if (width_chg_q) chg_seen_d = 1'b1;
        if (cnt_q == LAST_BIT) begin
          if (chg_seen_q || width_chg_q) begin
            start = 1'b1;
          end else begin
            state_d = PENDING;
            if (quot > STEP_MAX) begin
              result_d = '1;
              err_d    = 1'b1;
            end else begin
              result_d = quot[STEP_WIDTH-1:0];
            end
          end
        end
      end
      PENDING: begin
        // The held result is applied even when a restart coincides with the frame start.
        if (frame) begin
          step_d  = result_q;
          upd_d   = 1'b1;
          state_d = IDLE;
        end
        if (cfg_go || width_chg_q) start = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = DIVIDE;
      cnt_d      = '0;
      rem_d      = '0;
      chg_seen_d = 1'b0;
      dvd_d      = {in_width_q, {FRAC_BITS{1'b0}}};
      div_d      = cfg_go ? cfg_out_width : out_width_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      in_width_q   <= '0;
      meas_valid_q <= 1'b0;
      width_chg_q  <= 1'b0;
      out_width_q  <= '0;
      err_q        <= 1'b0;
      step_q       <= STEP_ONE;
      result_q     <= STEP_ONE;
      upd_q        <= 1'b0;
      chg_seen_q   <= 1'b0;
      cnt_q        <= '0;
      dvd_q        <= '0;
      rem_q        <= '0;
      div_q        <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      in_width_q   <= in_width_d;
      meas_valid_q <= meas_valid_d;
      width_chg_q  <= width_chg_d;
      out_width_q  <= out_width_d;
      err_q        <= err_d;
      step_q       <= step_d;
      result_q     <= result_d;
      upd_q        <= upd_d;
      chg_seen_q   <= chg_seen_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
    end
  end
endmodule
